alu_seq_ctrl: RTL
=================

# alu_seq_ctrl

Operand/opcode sequencer that sits in front of the calculator ALU and drives its `a`, `b` and `sel` inputs. It accepts a byte stream over a valid/ready handshake (opcode beat, operand A beat, operand B beat) and presents the registered operands to the ALU. It then captures the ALU's `dout`/`flags` into a result register and offers that result downstream over a second valid/ready handshake. It is the initiating end of the ALU interface: the ALU stays purely combinational and this block owns all sequencing.

## Interface
- `DW`, 8, data width of input bytes, operands and result
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `in_data`  in  DW  command/operand byte
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  block can accept a byte; reset 0
- `alu_a`  out  DW  operand A to ALU `a`; reset 0
- `alu_b`  out  DW  operand B to ALU `b`; reset 0
- `alu_sel`  out  4  opcode to ALU `sel`; reset 0
- `alu_dout`  in  DW  ALU result
- `alu_flags`  in  4  ALU flags, passed through opaquely
- `out_data`  out  DW  captured result; reset 0
- `out_flags`  out  4  captured flags; reset 0
- `out_valid`  out  1  result available; reset 0
- `out_ready`  in  1  downstream accepts result
- `op_count`  out  8  completed-operation counter; reset 0

## Operation
- FSM states: `S_OP`, `S_A`, `S_B`, `S_EXEC`, `S_DONE`. Reset state is `S_OP`.
- A beat transfers on a rising edge with `in_valid && in_ready`.
- `in_ready` = 1 in `S_OP`, `S_A` and `S_B`. It is 0 in `S_EXEC` and `S_DONE`, and 0 while `rst` is high.
- `S_OP`: on a beat, `alu_sel` <= `in_data[3:0]` and the chain bit <= `in_data[4]`. Bits [7:5] are ignored. Next state is `S_A`, or `S_B` when a chain is taken (see Configuration).
- `S_A`: on a beat, `alu_a` <= `in_data`; go to `S_B`.
- `S_B`: on a beat, `alu_b` <= `in_data`; go to `S_EXEC`.
- `S_EXEC`: lasts exactly one cycle so the ALU output settles.
  - At its closing edge: `out_data` <= `alu_dout`, `out_flags` <= `alu_flags`, `out_valid` <= 1, `op_count` <= `op_count` + 1 (mod 256, wraps 255 -> 0).
  - The `last_valid` flag is set. Go to `S_DONE`.
- `S_DONE`: `out_valid` stays high, and `out_data`/`out_flags` stay stable, until `out_ready` is sampled high. On that edge `out_valid` <= 0 and the FSM returns to `S_OP`.
- `alu_a`, `alu_b` and `alu_sel` hold their last values between operations and are never cleared except by reset.
- Opcode values 0xC–0xF are forwarded unchanged. The result is whatever the ALU returns for its default case; the block performs no opcode checking.
- `in_valid` outside the loading states is ignored and no data is lost or buffered; the upstream must hold the byte.
- Asynchronous reset mid-operation:
  - FSM returns to `S_OP` immediately.
  - All registered outputs and `last_valid` clear to 0.
  - A partially loaded command is discarded.

## Timing
- One byte per cycle maximum when `in_valid` is held high.
- Latency: the B-beat edge is edge N. `S_EXEC` occupies the cycle after edge N, and `out_valid` is high in the cycle after edge N+1.
- Minimum full-command period: 3 beat cycles + 1 `S_EXEC` cycle + 1 `S_DONE` cycle, i.e. 5 cycles with `out_ready` held high. With chaining: 4 cycles.
- No combinational path from `in_valid` or `out_ready` to any output. `in_ready` depends on state and `rst` only.

## Configuration
- Macro `ALU_SEQ_CTRL_CHAIN_EN`.
- Defined:
  - An opcode beat with bit 4 = 1 while `last_valid` = 1 skips `S_A`. At that edge `alu_a` <= `out_data` (the last captured result) and the next state is `S_B`.
  - With `last_valid` = 0, bit 4 is ignored and `S_A` is entered normally.
- Not defined: bit 4 is always ignored, every command takes three beats, and `last_valid` may be omitted.

## Test plan
Bench instantiates the real ALU wired to the `alu_*` ports.
- Beats 0x00, 5, 7 with `out_ready` = 1 -> `out_data` = 12, `out_valid` high exactly 2 edges after the B beat, `op_count` = 1.
- Beats 0x01, 8, 8 -> `out_data` = 0; `out_flags` equals the ALU's SUB-zero flag vector; `alu_a`/`alu_b` remain 8/8 afterwards.
- Beats 0x02, 6, 4 with `out_ready` low for 5 cycles -> `out_valid` = 1 and `out_data` = 24 stable throughout, `in_ready` = 0; releasing `out_ready` returns to `S_OP` in 1 cycle.
- With `ALU_SEQ_CTRL_CHAIN_EN`: after result 12, beats 0x10, 3 -> `alu_a` = 12, `out_data` = 15 with only two beats consumed. Without the macro, the same stream yields `alu_a` = 3 and waits for a third beat.
- Assert `rst` while in `S_B` -> all outputs 0, `in_ready` 0 during reset; after release, a fresh 0x00, 1, 1 gives 2.
- 256 back-to-back operations -> `op_count` wraps to 0.

Source files
------------

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if -- bundle of every non-clock signal around alu_seq_ctrl.
//   in_data/in_valid/in_ready      : command/operand byte stream (upstream)
//   alu_a/alu_b/alu_sel            : operands and opcode presented to the ALU
//   alu_dout/alu_flags             : combinational ALU response
//   out_data/out_flags/out_valid/out_ready : captured result stream (downstream)
//   op_count                       : completed-operation counter
// Modports:
//   master : the surroundings (upstream source, ALU, downstream sink)
//   slave  : the sequencer itself
interface alu_seq_ctrl_if #(
  parameter int unsigned DW = 8
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_sel;
  logic [DW-1:0] alu_dout;
  logic [3:0]    alu_flags;
  logic [DW-1:0] out_data;
  logic [3:0]    out_flags;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    op_count;

  modport master (
    output in_data, in_valid, alu_dout, alu_flags, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, out_data, out_flags, out_valid, op_count
  );

  modport slave (
    input  in_data, in_valid, alu_dout, alu_flags, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, out_data, out_flags, out_valid, op_count
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl -- operand/opcode sequencer in front of a combinational ALU.
// Loads opcode, operand A and operand B beats from a valid/ready byte stream,
// drives them to the ALU, waits one cycle for the ALU to settle, captures
// dout/flags and offers them downstream over a second valid/ready handshake.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : alu_seq_ctrl_if.slave (byte stream in, ALU drive/response,
//         result stream out, op_count)
// Optional feature: define ALU_SEQ_CTRL_CHAIN_EN to let an opcode beat with
// bit 4 set reuse the last captured result as operand A (skips the A beat).
module alu_seq_ctrl #(
  parameter int unsigned DW = 8
) (
  input logic          clk,
  input logic          rst,
  alu_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {S_OP, S_A, S_B, S_EXEC, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [3:0]    alu_sel_q, alu_sel_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [3:0]    out_flags_q, out_flags_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    op_count_q, op_count_d;
  logic          in_ready;
  logic          beat;
  logic          chain_take;

`ifdef ALU_SEQ_CTRL_CHAIN_EN
  logic          last_valid_q, last_valid_d;
  // Chaining is only meaningful once a result has actually been captured.
  assign chain_take = bus.in_data[4] && last_valid_q;
`else
  assign chain_take = 1'b0;
`endif

  assign beat = bus.in_valid && in_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_OP;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OP:    if (beat) state_d = chain_take ? S_B : S_A;
      S_A:     if (beat) state_d = S_B;
      S_B:     if (beat) state_d = S_EXEC;
      S_EXEC:  state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_OP;
      default: state_d = S_OP;
    endcase
  end

  // Output logic: ready depends on state and reset only
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        S_OP, S_A, S_B: in_ready = 1'b1;
        default:        in_ready = 1'b0;
      endcase
    end
  end

  // Datapath next values; everything holds unless its loading state says otherwise
  always_comb begin
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    out_valid_d = out_valid_q;
    op_count_d  = op_count_q;
`ifdef ALU_SEQ_CTRL_CHAIN_EN
    last_valid_d = last_valid_q;
`endif
    case (state_q)
      S_OP: begin
        if (beat) begin
          alu_sel_d = bus.in_data[3:0];
          if (chain_take) alu_a_d = out_data_q;
        end
      end
      S_A: if (beat) alu_a_d = bus.in_data;
      S_B: if (beat) alu_b_d = bus.in_data;
      S_EXEC: begin
        out_data_d  = bus.alu_dout;
        out_flags_d = bus.alu_flags;
        out_valid_d = 1'b1;
        op_count_d  = op_count_q + 8'd1;
`ifdef ALU_SEQ_CTRL_CHAIN_EN
        last_valid_d = 1'b1;
`endif
      end
      S_DONE: if (bus.out_ready) out_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      out_data_q  <= '0;
      out_flags_q <= '0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
`ifdef ALU_SEQ_CTRL_CHAIN_EN
      last_valid_q <= 1'b0;
`endif
    end else begin
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
      out_valid_q <= out_valid_d;
      op_count_q  <= op_count_d;
`ifdef ALU_SEQ_CTRL_CHAIN_EN
      last_valid_q <= last_valid_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_flags = out_flags_q;
  assign bus.out_valid = out_valid_q;
  assign bus.op_count  = op_count_q;

endmodule
